// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: sequential, branch, jump, call/return via a circular RAS.
// Define PC_TRAP_EN to add trap entry (trap_req -> TRAP_VEC) and exception return via epc_out.
module pc_seq_unit #(
    parameter int unsigned PC_BITS     = 8,
    parameter int unsigned INSTR_BYTES = 2,
    parameter int unsigned RAS_DEPTH   = 4,
    parameter int unsigned RESET_VEC   = 0,
    parameter int unsigned TRAP_VEC    = 'hF0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pc_latch_data,
    input  logic                           stall,
    input  logic [2:0]                     pc_ctl,
    input  logic [PC_BITS-1:0]             imm,
    input  logic [PC_BITS-1:0]             sr1_val,
`ifdef PC_TRAP_EN
    input  logic                           trap_req,
    output logic [PC_BITS-1:0]             epc_out,
`endif
    output logic [PC_BITS-1:0]             pc_out,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow,
    output logic                           misalign_err
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [PC_BITS-1:0] ALIGN_MASK = PC_BITS'(INSTR_BYTES - 1);
    localparam logic [PC_BITS-1:0] STEP       = PC_BITS'(INSTR_BYTES);
    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        CTL_SEQ  = 3'b000,
        CTL_REL  = 3'b001,
        CTL_JMP  = 3'b010,
        CTL_CALL = 3'b011,
        CTL_RET  = 3'b100,
        CTL_ERET = 3'b101
    } pc_ctl_e;

    logic [PC_BITS-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   top_ptr;    // slot the next push writes

    logic               advance;
    logic [PC_BITS-1:0] seq_pc;
    logic [PC_BITS-1:0] rel_pc;
    logic [PC_BITS-1:0] jmp_pc;
    logic [PC_BITS-1:0] next_pc;
    logic [PTR_W-1:0]   ptr_inc;
    logic [PTR_W-1:0]   ptr_dec;
    logic [PTR_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   next_cnt;
    logic               push;
    logic               set_ovf;
    logic               set_unf;
    logic               set_mis;

    assign advance = pc_latch_data & ~stall;

    // Next-PC and RAS bookkeeping for one advance
    always_comb begin
        seq_pc   = pc_out + STEP;
        rel_pc   = pc_out + imm;
        jmp_pc   = sr1_val & ~ALIGN_MASK;
        ptr_inc  = (top_ptr == PTR_LAST) ? '0 : top_ptr + PTR_W'(1);
        ptr_dec  = (top_ptr == '0) ? PTR_LAST : top_ptr - PTR_W'(1);
        next_pc  = seq_pc;
        next_ptr = top_ptr;
        next_cnt = ras_count;
        push     = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        set_mis  = 1'b0;
        case (pc_ctl)
            CTL_REL: begin
                next_pc = rel_pc;
            end
            CTL_JMP: begin
                next_pc = jmp_pc;
                set_mis = |(sr1_val & ALIGN_MASK);
            end
            CTL_CALL: begin
                // A push while full lands on the oldest slot, which top_ptr points at
                next_pc  = rel_pc;
                push     = 1'b1;
                next_ptr = ptr_inc;
                if (ras_count == CNT_FULL) begin
                    set_ovf = 1'b1;
                end else begin
                    next_cnt = ras_count + CNT_W'(1);
                end
            end
            CTL_RET: begin
                if (ras_count == '0) begin
                    set_unf = 1'b1;
                end else begin
                    next_pc  = ras_mem[ptr_dec];
                    next_ptr = ptr_dec;
                    next_cnt = ras_count - CNT_W'(1);
                end
            end
`ifdef PC_TRAP_EN
            CTL_ERET: begin
                next_pc = epc_out;
            end
`endif
            default: begin
                next_pc = seq_pc;
            end
        endcase
    end

`ifndef PC_TRAP_EN
    // TRAP_VEC has no effect without the trap feature
    if (TRAP_VEC != 0) begin : g_trap_vec_unused
    end
`endif

    // State update: reset, then trap, then a normal advance
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out        <= PC_BITS'(RESET_VEC);
            top_ptr       <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            misalign_err  <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
`ifdef PC_TRAP_EN
            epc_out       <= '0;
`endif
        end
`ifdef PC_TRAP_EN
        else if (trap_req) begin
            epc_out <= pc_out;
            pc_out  <= PC_BITS'(TRAP_VEC);
        end
`endif
        else if (advance) begin
            pc_out        <= next_pc;
            top_ptr       <= next_ptr;
            ras_count     <= next_cnt;
            ras_overflow  <= ras_overflow | set_ovf;
            ras_underflow <= ras_underflow | set_unf;
            misalign_err  <= misalign_err | set_mis;
            if (push) begin
                ras_mem[top_ptr] <= seq_pc;
            end
        end
    end

endmodule
